iter_shifter: RTL and testbench
===============================

ITER_SHIFTER -- requirements
Module: iter_shifter

Interface
REQ-001 SHALL have no parameters; all widths are fixed.
REQ-002 SHALL have port: clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: req_val  input  1  request valid.
REQ-005 SHALL have port: req_rdy  output  1  request ready.
REQ-006 SHALL have port: req_data  input  8  operand to shift.
REQ-007 SHALL have port: req_amt  input  4  total shift amount, 0..15.
REQ-008 SHALL have port: req_op  input  1  0 = logical left, 1 = logical right.
REQ-009 SHALL have port: resp_val  output  1  response valid.
REQ-010 SHALL have port: resp_rdy  input  1  response ready.
REQ-011 SHALL have port: resp_data  output  8  shifted result.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-013 SHALL drive req_rdy=1 only in IDLE, and resp_val=1 only in DONE; no request/response overlap.
REQ-014 SHALL, in IDLE with req_val=1, latch req_data, req_amt and req_op into internal registers at that edge (the accept edge).
REQ-015 SHALL go from IDLE to DONE at the accept edge when req_amt=0, with resp_data equal to req_data.
REQ-016 SHALL go from IDLE to CALC at the accept edge when req_amt>0.
REQ-017 SHALL, each CALC cycle, apply step = min(remaining, 7) using the 8-bit combinational shifter and subtract step from remaining.
REQ-018 SHALL move from CALC to DONE on the edge where remaining becomes 0; CALC lasts ceil(amt/7) cycles (1 for 1..7, 2 for 8..14, 3 for 15).
REQ-019 SHALL give resp_val latency after the accept edge of 1 + ceil(amt/7) cycles.
REQ-020 SHALL shift logically: vacated bits are 0, and any amt >= 8 yields 0x00.
REQ-021 SHALL hold resp_data stable in DONE until resp_val && resp_rdy, then return to IDLE on that edge.
REQ-022 SHALL keep resp_data holding the last result in IDLE and CALC; it is only meaningful while resp_val=1.
REQ-023 SHALL ignore req_val, req_data, req_amt and req_op outside IDLE.
REQ-024 SHALL ignore resp_rdy outside DONE.

Reset
REQ-025 SHALL, on any edge with reset=1, enter IDLE and clear the data register, remaining and op to 0, taking priority over all other activity.
REQ-026 SHALL produce req_rdy=1, resp_val=0 and resp_data=0x00 in the cycle after reset.
REQ-027 SHALL, on reset mid-CALC or mid-DONE, discard the in-flight operation with no response.

Structure
REQ-028 SHALL place in a shared package: the FSM state enum {IDLE, CALC, DONE} and the constant STEP_MAX = 7.
REQ-029 SHALL instantiate one combinational sub-module, shifter_8b (8-bit data, 3-bit amount, op), for the per-cycle step.
REQ-030 SHALL register all outputs or derive them solely from FSM state; there is no combinational path from inputs to outputs.

Verification
REQ-031 SHALL cover: reset asserted 2 cycles -> req_rdy=1, resp_val=0, resp_data=0x00.
REQ-032 SHALL cover: req 0xB5, amt 0, op 0 -> resp_val 1 cycle after accept, resp_data=0xB5.
REQ-033 SHALL cover: req 0x81, amt 3, op 0 -> resp_data=0x08 with 2-cycle latency; and 0x81, amt 3, op 1 -> resp_data=0x10.
REQ-034 SHALL cover: req 0xFF, amt 15, op 1 -> three CALC cycles (7, 7, 1), resp_data=0x00, resp_val 4 cycles after accept.
REQ-035 SHALL cover: resp_rdy held 0 for 5 cycles in DONE -> resp_val=1, resp_data stable, req_rdy=0 throughout; accept on resp_rdy=1 -> IDLE next cycle.
REQ-036 SHALL cover: reset pulsed during the second CALC cycle of amt 14 -> IDLE next cycle, no resp_val, then a new request 0x03 amt 1 op 0 -> 0x06.

Source files
------------

// File: rtl/iter_shifter_pkg.sv
// Shared types and constants for the iterative shifter.
package iter_shifter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Largest distance the per-cycle shifter moves data in one CALC cycle.
  localparam logic [3:0] STEP_MAX = 4'd7;

  // Distance to shift this cycle: whatever is left, capped at STEP_MAX.
  function automatic logic [2:0] step_of(input logic [3:0] remaining);
    return (remaining > STEP_MAX) ? STEP_MAX[2:0] : remaining[2:0];
  endfunction

endpackage

// File: rtl/iter_shifter_shifter_8b.sv
// Combinational 8-bit logical shifter, 0..7 positions, left (op=0) or right (op=1).
// A right shift is done as bit-reverse, left shift, bit-reverse so one
// left shifter serves both directions.
module shifter_8b (
  input  logic [7:0] data,
  input  logic [2:0] amt,
  input  logic       op,
  output logic [7:0] result
);

  logic [7:0] data_rev;
  logic [7:0] shl_in;
  logic [7:0] shl_out;
  logic [7:0] shl_rev;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_rev
      assign data_rev[gi] = data[7-gi];
      assign shl_rev[gi]  = shl_out[7-gi];
    end
  endgenerate

  assign shl_in  = op ? data_rev : data;
  assign shl_out = shl_in << amt;
  assign result  = op ? shl_rev : shl_out;

endmodule

// File: rtl/iter_shifter.sv
// Iterative shifter: accepts an 8-bit operand and a 0..15 shift amount, then
// shifts by at most STEP_MAX per cycle until the full amount is applied.
module iter_shifter
  import iter_shifter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       req_val,
  output logic       req_rdy,
  input  logic [7:0] req_data,
  input  logic [3:0] req_amt,
  input  logic       req_op,
  output logic       resp_val,
  input  logic       resp_rdy,
  output logic [7:0] resp_data
);

  state_t     state_reg, state_next;
  logic [7:0] data_reg, data_next;
  logic [3:0] rem_reg, rem_next;
  logic       op_reg, op_next;

  logic [2:0] step;
  logic [7:0] shifted;

  assign step = step_of(rem_reg);

  shifter_8b u_shifter (
    .data   (data_reg),
    .amt    (step),
    .op     (op_reg),
    .result (shifted)
  );

  // State and datapath registers; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      data_reg  <= 8'h00;
      rem_reg   <= 4'd0;
      op_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
      rem_reg   <= rem_next;
      op_reg    <= op_next;
    end
  end

  // Next-state and datapath update: latch in IDLE, step in CALC, hold in DONE.
  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    rem_next   = rem_reg;
    op_next    = op_reg;
    unique case (state_reg)
      IDLE: begin
        if (req_val) begin
          data_next  = req_data;
          rem_next   = req_amt;
          op_next    = req_op;
          state_next = (req_amt == 4'd0) ? DONE : CALC;
        end
      end
      CALC: begin
        data_next = shifted;
        rem_next  = rem_reg - {1'b0, step};
        if (rem_next == 4'd0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (resp_rdy) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs come only from state and registered data.
  assign req_rdy   = (state_reg == IDLE);
  assign resp_val  = (state_reg == DONE);
  assign resp_data = data_reg;

endmodule

// File: tb/tb_iter_shifter.sv
// Self-checking bench for iter_shifter: transaction-level reference model plus
// directed and randomized requests.
module tb_iter_shifter;

  logic       clk;
  logic       reset;
  logic       req_val;
  logic       req_rdy;
  logic [7:0] req_data;
  logic [3:0] req_amt;
  logic       req_op;
  logic       resp_val;
  logic       resp_rdy;
  logic [7:0] resp_data;

  int checks = 0;
  int errors = 0;

  iter_shifter dut (
    .clk       (clk),
    .reset     (reset),
    .req_val   (req_val),
    .req_rdy   (req_rdy),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .req_op    (req_op),
    .resp_val  (resp_val),
    .resp_rdy  (resp_rdy),
    .resp_data (resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result: plain arithmetic on the whole amount.
  function automatic int ref_shift(input int d, input int amt, input int op);
    if (amt >= 8) return 0;
    if (op != 0) return d >> amt;
    return (d << amt) & 255;
  endfunction

  // Cycles from accept to resp_val: 1 + ceil(amt/7).
  function automatic int ref_lat(input int amt);
    return 1 + (amt + 6) / 7;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Transaction-level model, advanced on each rising edge from bench inputs.
  bit m_on   = 1'b0;
  bit m_busy = 1'b0;
  bit m_done = 1'b0;
  int m_wait = 0;
  int m_data = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_on   = 1'b1;
      m_busy = 1'b0;
      m_done = 1'b0;
      m_data = 0;
    end else if (m_on) begin
      if (m_done) begin
        if (resp_rdy) m_done = 1'b0;
      end else if (m_busy) begin
        m_wait--;
        if (m_wait == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end else if (req_val) begin
        m_data = ref_shift(int'(req_data), int'(req_amt), int'(req_op));
        m_wait = (int'(req_amt) + 6) / 7;
        if (m_wait == 0) m_done = 1'b1;
        else m_busy = 1'b1;
      end
    end
  end

  // Compare DUT outputs against the model every cycle, away from the edge.
  always @(negedge clk) begin
    if (m_on) begin
      check("req_rdy", int'(req_rdy), int'(!m_busy && !m_done));
      check("resp_val", int'(resp_val), int'(m_done));
      if (!m_busy) check("resp_data", int'(resp_data), m_data);
    end
  end

  task automatic junk_inputs();
    req_val  = 1'($urandom_range(0, 1));
    req_data = 8'($urandom);
    req_amt  = 4'($urandom);
    req_op   = 1'($urandom_range(0, 1));
  endtask

  // One full request/response; called and returns on a falling edge.
  task automatic do_req(input logic [7:0] d, input logic [3:0] a, input logic o,
                        input int hold, input int exp_d, input int exp_lat);
    int lat;
    bit got;
    bit rdy_seen;
    rdy_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_rdy) begin
        rdy_seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("wait_req_rdy", int'(rdy_seen), 1);
    req_val  = 1'b1;
    req_data = d;
    req_amt  = a;
    req_op   = o;
    resp_rdy = 1'b0;
    @(negedge clk);
    lat = 1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (resp_val) begin
        got = 1'b1;
        break;
      end
      junk_inputs();
      @(negedge clk);
      lat++;
    end
    check("latency", got ? lat : -1, exp_lat);
    check("result", int'(resp_data), exp_d);
    for (int i = 0; i < hold; i++) begin
      junk_inputs();
      @(negedge clk);
      check("hold_val", int'(resp_val), 1);
      check("hold_rdy", int'(req_rdy), 0);
      check("hold_data", int'(resp_data), exp_d);
    end
    req_val  = 1'b0;
    resp_rdy = 1'b1;
    @(negedge clk);
    resp_rdy = 1'b0;
    check("back_idle", int'(req_rdy), 1);
    $display("txn data=0x%02h amt=%0d op=%0d -> resp=0x%02h lat=%0d hold=%0d",
             d, a, o, resp_data, lat, hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    logic [3:0] a;
    logic       o;
    int         hold;

    reset    = 1'b1;
    req_val  = 1'b0;
    req_data = 8'h00;
    req_amt  = 4'd0;
    req_op   = 1'b0;
    resp_rdy = 1'b0;

    // Pin the reference model with hand-computed values.
    check("model_b5_0", ref_shift(8'hB5, 0, 0), 8'hB5);
    check("model_81_3l", ref_shift(8'h81, 3, 0), 8'h08);
    check("model_81_3r", ref_shift(8'h81, 3, 1), 8'h10);
    check("model_ff_15r", ref_shift(8'hFF, 15, 1), 8'h00);
    check("model_03_1l", ref_shift(8'h03, 1, 0), 8'h06);
    check("model_lat15", ref_lat(15), 4);

    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_req_rdy", int'(req_rdy), 1);
    check("rst_resp_val", int'(resp_val), 0);
    check("rst_resp_data", int'(resp_data), 0);
    $display("txn reset -> req_rdy=%0d resp_val=%0d resp_data=0x%02h",
             req_rdy, resp_val, resp_data);

    do_req(8'hB5, 4'd0, 1'b0, 0, 8'hB5, 1);
    do_req(8'h81, 4'd3, 1'b0, 1, 8'h08, 2);
    do_req(8'h81, 4'd3, 1'b1, 5, 8'h10, 2);
    do_req(8'hFF, 4'd15, 1'b1, 0, 8'h00, 4);
    do_req(8'h01, 4'd7, 1'b0, 0, 8'h80, 2);
    do_req(8'hFF, 4'd8, 1'b0, 0, 8'h00, 3);

    // Reset during the second CALC cycle of an amt-14 request.
    req_val  = 1'b1;
    req_data = 8'hA7;
    req_amt  = 4'd14;
    req_op   = 1'b0;
    @(negedge clk);
    req_val = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_req_rdy", int'(req_rdy), 1);
    check("abort_resp_val", int'(resp_val), 0);
    check("abort_resp_data", int'(resp_data), 0);
    $display("txn data=0xa7 amt=14 aborted by reset -> req_rdy=%0d resp_val=%0d",
             req_rdy, resp_val);
    do_req(8'h03, 4'd1, 1'b0, 0, 8'h06, 2);

    // Randomized requests with random gaps and response back-pressure.
    for (int n = 0; n < 40; n++) begin
      d    = 8'($urandom);
      a    = 4'($urandom_range(0, 15));
      o    = 1'($urandom_range(0, 1));
      hold = $urandom_range(0, 3);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_req(d, a, o, hold, ref_shift(int'(d), int'(a), int'(o)), ref_lat(int'(a)));
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
